// File: rtl/sbox_scheduler.sv
// Serialises a 128-bit state through one shared, pipelined S-box, one byte per cycle,
// and reassembles the substituted bytes into state_out.
module sbox_scheduler #(
   parameter int SBOX_LAT = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         inv,
   input  logic [127:0] state_in,
   output logic [7:0]   sbox_in,
   output logic         sbox_vld,
   output logic         sbox_inv,
   input  logic [7:0]   sbox_out,
   output logic         busy,
   output logic         done,
   output logic [127:0] state_out
);

   // state | meaning
   // IDLE  | waiting for start
   // ISSUE | presenting byte[issue_cnt] to the S-box
   // DRAIN | all bytes issued, collecting remaining results
   // DONE  | one-cycle completion pulse; start accepted here too
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t       state, state_nxt;
   logic [127:0] data_q;
   logic         inv_q;
   logic [3:0]   issue_cnt;
   logic [3:0]   cap_cnt;
   logic         cap_vld;
   logic         accept;
   logic         last_cap;

   generate
      if (SBOX_LAT == 0) begin : g_nodly
         assign cap_vld = sbox_vld;
      end else begin : g_dly
         logic [SBOX_LAT-1:0] vld_dly;
         always_ff @(posedge clk) begin
            if (!rst_n) vld_dly <= '0;
            else        vld_dly <= (vld_dly << 1) | SBOX_LAT'(sbox_vld);
         end
         assign cap_vld = vld_dly[SBOX_LAT-1];
      end
   endgenerate

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_cap = cap_vld && (cap_cnt == 4'd15);
   assign sbox_inv = inv_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sbox_vld  = 1'b0;
      sbox_in   = 8'h00;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE, DONE: begin
            done      = (state == DONE);
            state_nxt = start ? ISSUE : IDLE;
         end
         ISSUE: begin
            busy     = 1'b1;
            sbox_vld = 1'b1;
            sbox_in  = data_q[{issue_cnt, 3'b000} +: 8];
            if (issue_cnt == 4'd15) state_nxt = last_cap ? DONE : DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_cap) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture never coincides with accept: the delay line is empty in IDLE/DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         inv_q     <= 1'b0;
         issue_cnt <= '0;
         cap_cnt   <= '0;
         state_out <= '0;
      end else begin
         if (accept) begin
            data_q    <= state_in;
            inv_q     <= inv;
            issue_cnt <= '0;
            cap_cnt   <= '0;
         end else if (state == ISSUE) begin
            issue_cnt <= issue_cnt + 4'd1;
         end
         if (cap_vld) begin
            state_out[{cap_cnt, 3'b000} +: 8] <= sbox_out;
            cap_cnt                           <= cap_cnt + 4'd1;
         end
      end
   end

endmodule

// File: doc/sbox_scheduler.md
SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 The block SHALL have one parameter: SBOX_LAT, default 2, register stages inside the shared external S-box (legal range 0..4).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge only.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port start, input, 1 bit: request to run SubBytes on state_in; sampled only in IDLE or DONE.
REQ-005 Port inv, input, 1 bit: 0 = forward S-box, 1 = inverse S-box; latched with start.
REQ-006 Port state_in, input, 128 bits: byte i = state_in[8i+7:8i]; latched with start.
REQ-007 Port sbox_in, output, 8 bits: byte presented to the shared S-box.
REQ-008 Port sbox_vld, output, 1 bit: sbox_in holds a valid byte this cycle.
REQ-009 Port sbox_inv, output, 1 bit: mode select to the S-box; equals the latched inv throughout a run.
REQ-010 Port sbox_out, input, 8 bits: S-box result, valid SBOX_LAT cycles after the matching sbox_vld cycle.
REQ-011 Port busy, output, 1 bit: a run is in progress.
REQ-012 Port done, output, 1 bit: single-cycle pulse when state_out is complete.
REQ-013 Port state_out, output, 128 bits: substituted state in the same byte order as state_in.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE/DONE with start=1: latch state_in and inv, clear the issue and capture counters, go to ISSUE; start=0: go to (or stay in) IDLE.
REQ-016 ISSUE: drive sbox_vld=1 and sbox_in=latched byte[issue_cnt], with issue_cnt counting 0..15, one byte per cycle and no gaps; after byte 15, go to DRAIN, or to DONE directly if the final capture happens in that same cycle.
REQ-017 A SBOX_LAT-deep valid delay line (tracking sbox_vld) SHALL gate capture; on each edge where its output is 1, write sbox_out into state_out byte[cap_cnt] and increment cap_cnt (4 bits). With SBOX_LAT=0 the capture uses the undelayed sbox_vld and sbox_out in the same cycle.
REQ-018 DRAIN: sbox_vld=0; go to DONE on the edge that captures byte 15.
REQ-019 DONE: lasts exactly one cycle, with done=1 and busy=0.
REQ-020 busy SHALL be 1 in ISSUE and DRAIN, and 0 otherwise.
REQ-021 Timing: start sampled at the end of cycle T -> byte i issued in cycle T+1+i -> captured at the end of cycle T+1+i+SBOX_LAT -> done=1 in cycle T+17+SBOX_LAT.
REQ-022 state_out SHALL hold its value from DONE until the next accepted start; bytes are overwritten progressively during a run.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the counters, the latched data or the outputs.
REQ-024 start=1 in the DONE cycle SHALL be accepted, so back-to-back runs have no idle cycle.
REQ-025 sbox_in SHALL be 8'h00 whenever sbox_vld=0.
REQ-026 sbox_out SHALL be ignored whenever the delayed valid is 0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force: state IDLE; busy=0; done=0; sbox_vld=0; sbox_in=0; sbox_inv=0; state_out=0; counters=0; delay line=0.
REQ-028 Reset mid-run SHALL abort immediately; in-flight S-box results SHALL never be captured, and the first start after reset SHALL behave as from power-up.

Verification
REQ-029 Golden S-box model, SBOX_LAT=2, state_in=0, inv=0, start at T -> sbox_vld high in cycles T+1..T+16, done in T+19, state_out=all 8'h63.
REQ-030 state_in=all 8'h63, inv=1 -> sbox_inv=1 for the whole run, state_out=all 8'h00, done in T+19.
REQ-031 start pulsed again at T+5 with different state_in -> ignored; result matches the first state_in; exactly one done pulse.
REQ-032 rst_n=0 for one cycle at T+8 -> next cycle busy=0, sbox_vld=0, state_out=0, no done; a new start then completes normally with done 19 cycles later.
REQ-033 start held high through the DONE cycle -> second run starts with no gap; second done 19 cycles after the first.
REQ-034 SBOX_LAT=0 with a combinational model, state_in byte i = i -> done in T+17; byte i of state_out = S-box(i) (byte0=8'h63, byte1=8'h7c, byte15=8'h76).
